// File: rtl/rename_queue_if.sv
// rename_queue_if: decode-side enqueue and rename-side dequeue handshakes of the rename queue.
interface rename_queue_if #(
    parameter int PAYLOAD_W = 160
);
    logic [1:0]                in_valid;
    logic [1:0][PAYLOAD_W-1:0] in_payload;
    logic [1:0]                in_tag;
    logic                      in_ready;
    logic [1:0]                out_valid;
    logic [1:0][PAYLOAD_W-1:0] out_payload;
    logic [1:0]                out_tag;
    logic [1:0]                out_ready;
    modport master (
        output in_valid, in_payload, in_tag, out_ready,
        input  in_ready, out_valid, out_payload, out_tag
    );
    modport slave (
        input  in_valid, in_payload, in_tag, out_ready,
        output in_ready, out_valid, out_payload, out_tag
    );
endinterface

// File: rtl/rename_queue.sv
// rename_queue: dual-slot in-order FIFO between decode and rename with squash/commit of the tagged suffix.
module rename_queue #(
    parameter int PAYLOAD_W = 160,
    parameter int DEPTH     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   delete_tagged,
    input  logic                   clear_tags,
    rename_queue_if.slave          q,
    output logic [$clog2(DEPTH):0] queue_size
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     tags;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr1, rd1;
    logic [CNT_W-1:0]     count, tag_cnt;
    logic [1:0]           enq, deq, tag_enq, tag_deq;
    always_comb begin
        wr1             = wr_ptr + PTR_W'(1);
        rd1             = rd_ptr + PTR_W'(1);
        q.in_ready      = !delete_tagged && count <= CNT_W'(DEPTH - 2);
        q.out_valid[0]  = !delete_tagged && count != '0;
        q.out_valid[1]  = !delete_tagged && count >= CNT_W'(2);
        q.out_payload[0] = mem[rd_ptr];
        q.out_payload[1] = mem[rd1];
        q.out_tag       = {tags[rd1], tags[rd_ptr]};
        enq     = (q.in_ready && q.in_valid[0]) ? (q.in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
        deq     = (q.out_valid[0] && q.out_ready[0]) ? ((q.out_valid[1] && q.out_ready[1]) ? 2'd2 : 2'd1) : 2'd0;
        tag_enq = {1'b0, (|enq) & q.in_tag[0]} + {1'b0, enq[1] & q.in_tag[1]};
        tag_deq = {1'b0, (|deq) & tags[rd_ptr]} + {1'b0, deq[1] & tags[rd1]};
        queue_size = count;
    end
    // Payload RAM carries no reset; only occupancy and tags are architecturally reset.
    always_ff @(posedge clk) begin
        if (|enq) mem[wr_ptr] <= q.in_payload[0];
        if (enq[1]) mem[wr1] <= q.in_payload[1];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
            tags    <= '0;
        end else if (delete_tagged) begin
            // Tagged entries form the youngest suffix, so clearing every tag bit only affects the squashed ones.
            wr_ptr  <= wr_ptr - PTR_W'(tag_cnt);
            count   <= count - tag_cnt;
            tag_cnt <= '0;
            tags    <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(enq);
            rd_ptr  <= rd_ptr + PTR_W'(deq);
            count   <= count + CNT_W'(enq) - CNT_W'(deq);
            tag_cnt <= clear_tags ? '0 : tag_cnt + CNT_W'(tag_enq) - CNT_W'(tag_deq);
            if (clear_tags) begin
                tags <= '0;
            end else begin
                if (|deq) tags[rd_ptr] <= 1'b0;
                if (deq[1]) tags[rd1] <= 1'b0;
                if (|enq) tags[wr_ptr] <= q.in_tag[0];
                if (enq[1]) tags[wr1] <= q.in_tag[1];
            end
        end
    end
endmodule

// File: tb/tb_rename_queue.sv
// tb_rename_queue: directed scenario tests for rename_queue with hand-computed expectations.
module tb_rename_queue;
    localparam int PW    = 160;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic delete_tagged = 1'b0;
    logic clear_tags = 1'b0;
    logic [CNT_W-1:0] queue_size;
    int vecs = 0;
    int errs = 0;
    rename_queue_if #(.PAYLOAD_W(PW)) bus ();
    rename_queue #(.PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .delete_tagged(delete_tagged), .clear_tags(clear_tags),
        .q(bus), .queue_size(queue_size)
    );
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pv(int k);
        return {5{32'(k) ^ 32'hA5A50000}};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [1:0] v, logic [1:0] t, int k);
        bus.in_valid = v;
        bus.in_tag = t;
        bus.in_payload[0] = pv(k);
        bus.in_payload[1] = pv(k + 1);
    endtask

    task automatic idle;
        bus.in_valid = 2'b00;
        bus.in_tag = 2'b00;
        bus.out_ready = 2'b00;
        delete_tagged = 1'b0;
        clear_tags = 1'b0;
    endtask

    task automatic chk_size(string name, int exp);
        vecs++;
        if (queue_size !== CNT_W'(exp)) begin
            errs++;
            $display("FAIL %s queue_size got %0d exp %0d", name, queue_size, exp);
        end
    endtask

    task automatic test_reset;
        chk_size("reset_size", 0);
        vecs++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 2'b00 || bus.out_tag !== 2'b00) begin
            errs++;
            $display("FAIL reset_flags got rdy=%b ov=%b tag=%b exp 1 00 00", bus.in_ready, bus.out_valid, bus.out_tag);
        end
    endtask

    task automatic test_fill;
        int k;
        idle();
        for (int i = 0; i < 31; i++) begin
            drive(2'b11, 2'b00, 2 * i);
            step();
        end
        chk_size("fill_31", 62);
        vecs++;
        if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL fill_rdy62 got %b exp 1", bus.in_ready); end
        drive(2'b11, 2'b00, 62);
        step();
        chk_size("fill_32", 64);
        vecs++;
        if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL fill_rdy64 got %b exp 0", bus.in_ready); end
        drive(2'b11, 2'b00, 900);
        step();
        chk_size("fill_overflow", 64);
        idle();
        bus.out_ready = 2'b01;
        vecs++;
        if (bus.out_payload[0] !== pv(0)) begin errs++; $display("FAIL fill_head got %h exp %h", bus.out_payload[0], pv(0)); end
        step();
        chk_size("fill_63", 63);
        vecs++;
        if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL fill_rdy63 got %b exp 0", bus.in_ready); end
        bus.out_ready = 2'b11;
        k = 1;
        for (int i = 0; i < 32; i++) begin
            vecs++;
            if (bus.out_payload[0] !== pv(k)) begin errs++; $display("FAIL fill_order0 got %h exp %h", bus.out_payload[0], pv(k)); end
            if (k < 63) begin
                vecs++;
                if (bus.out_payload[1] !== pv(k + 1)) begin errs++; $display("FAIL fill_order1 got %h exp %h", bus.out_payload[1], pv(k + 1)); end
            end
            step();
            k += 2;
        end
        chk_size("fill_drained", 0);
        idle();
    endtask

    task automatic test_back_to_back;
        idle();
        bus.out_ready = 2'b11;
        drive(2'b11, 2'b00, 1000);
        step();
        for (int c = 1; c <= 110; c++) begin
            chk_size("b2b_size", 2);
            vecs++;
            if (bus.out_payload[0] !== pv(1000 + 2 * c - 2) || bus.out_payload[1] !== pv(1000 + 2 * c - 1)) begin
                errs++;
                $display("FAIL b2b_order cycle %0d got %h exp %h", c, bus.out_payload[0], pv(1000 + 2 * c - 2));
            end
            drive(2'b11, 2'b00, 1000 + 2 * c);
            step();
        end
        bus.in_valid = 2'b00;
        step();
        chk_size("b2b_drained", 0);
        idle();
    endtask

    task automatic test_delete_tagged;
        int exp_k[6] = '{200, 201, 202, 203, 204, 300};
        idle();
        drive(2'b11, 2'b00, 200); step();
        drive(2'b11, 2'b00, 202); step();
        drive(2'b01, 2'b00, 204); step();
        drive(2'b11, 2'b11, 205); step();
        drive(2'b01, 2'b01, 207); step();
        chk_size("del_before", 8);
        idle();
        bus.out_ready = 2'b11;
        delete_tagged = 1'b1;
        #1;
        vecs++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 2'b00) begin
            errs++;
            $display("FAIL del_stall got rdy=%b ov=%b exp 0 00", bus.in_ready, bus.out_valid);
        end
        step();
        delete_tagged = 1'b0;
        bus.out_ready = 2'b00;
        chk_size("del_after", 5);
        drive(2'b01, 2'b00, 300);
        step();
        idle();
        chk_size("del_enq", 6);
        bus.out_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (bus.out_payload[0] !== pv(exp_k[2 * i]) || bus.out_payload[1] !== pv(exp_k[2 * i + 1]) || bus.out_tag !== 2'b00) begin
                errs++;
                $display("FAIL del_order pair %0d got %h tag %b exp %h tag 00", i, bus.out_payload[0], bus.out_tag, pv(exp_k[2 * i]));
            end
            step();
        end
        chk_size("del_drained", 0);
        idle();
    endtask

    task automatic test_clear_tags;
        idle();
        drive(2'b11, 2'b11, 400); step();
        drive(2'b11, 2'b11, 402); step();
        vecs++;
        if (bus.out_tag !== 2'b11) begin errs++; $display("FAIL clr_tagged got %b exp 11", bus.out_tag); end
        clear_tags = 1'b1;
        drive(2'b11, 2'b11, 404);
        step();
        idle();
        chk_size("clr_size", 6);
        delete_tagged = 1'b1;
        step();
        delete_tagged = 1'b0;
        chk_size("clr_nodelete", 6);
        bus.out_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (bus.out_payload[0] !== pv(400 + 2 * i) || bus.out_payload[1] !== pv(401 + 2 * i) || bus.out_tag !== 2'b00) begin
                errs++;
                $display("FAIL clr_order pair %0d got %h tag %b exp %h tag 00", i, bus.out_payload[0], bus.out_tag, pv(400 + 2 * i));
            end
            step();
        end
        chk_size("clr_drained", 0);
        idle();
    endtask

    task automatic test_partial_slots;
        idle();
        drive(2'b11, 2'b00, 500); step();
        drive(2'b01, 2'b00, 502); step();
        idle();
        bus.out_ready = 2'b10;
        step();
        chk_size("part_outrdy10", 3);
        vecs++;
        if (bus.out_valid !== 2'b11) begin errs++; $display("FAIL part_valid got %b exp 11", bus.out_valid); end
        bus.out_ready = 2'b00;
        drive(2'b10, 2'b00, 600);
        step();
        chk_size("part_invalid10", 3);
        idle();
        bus.out_ready = 2'b01;
        step();
        chk_size("part_deq1", 2);
        vecs++;
        if (bus.out_payload[0] !== pv(501)) begin errs++; $display("FAIL part_head got %h exp %h", bus.out_payload[0], pv(501)); end
        bus.out_ready = 2'b11;
        step();
        chk_size("part_drained", 0);
        idle();
    endtask

    task automatic test_reset_mid;
        idle();
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 2'b00, 700 + 2 * i);
            step();
        end
        chk_size("rst_before", 10);
        idle();
        reset = 1'b0;
        #1;
        chk_size("rst_async", 0);
        vecs++;
        if (bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_flags got ov=%b rdy=%b exp 00 1", bus.out_valid, bus.in_ready);
        end
        step();
        reset = 1'b1;
        step();
        vecs++;
        if (bus.out_valid !== 2'b00) begin errs++; $display("FAIL rst_stale got %b exp 00", bus.out_valid); end
        drive(2'b01, 2'b00, 800);
        step();
        idle();
        chk_size("rst_enq", 1);
        vecs++;
        if (bus.out_valid !== 2'b01 || bus.out_payload[0] !== pv(800)) begin
            errs++;
            $display("FAIL rst_newhead got ov=%b %h exp 01 %h", bus.out_valid, bus.out_payload[0], pv(800));
        end
    endtask

    initial begin
        idle();
        bus.in_payload = '0;
        step();
        step();
        reset = 1'b1;
        step();
        test_reset();
        test_fill();
        test_back_to_back();
        test_delete_tagged();
        test_clear_tags();
        test_partial_slots();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
